// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: state encoding, default
// width and the DIV/DIVU funct codes the decoder uses to raise start/is_signed.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    // Decoder helper: does this R-type funct request the divider?
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step: shift {P,Q} left, trial-subtract D,
// keep the difference and set the quotient bit when it is non-negative.
module div_unit_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_p,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_p,
    output logic [WIDTH-1:0] o_q
);

    localparam int unsigned TW = WIDTH + 2;

    logic [TW-1:0] w_shift;
    logic [TW-1:0] w_trial;

    // Extra top bit of the trial result acts as the borrow/sign flag.
    assign w_shift = {i_p, i_q[WIDTH-1]};
    assign w_trial = w_shift - TW'(i_d);

    always_comb begin
        o_p = w_shift[WIDTH:0];
        o_q = {i_q[WIDTH-2:0], 1'b0};
        if (!w_trial[TW-1]) begin
            o_p    = w_trial[WIDTH:0];
            o_q[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for the EX stage. Quotient goes
// to LO, remainder to HI; stall holds the pipeline while the divider iterates.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_dvd_raw;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;

    logic             w_accept;
    logic             w_last;
    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH:0]   w_p_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    assign w_accept = (r_state == ST_IDLE) && start && !clear;
    assign w_last   = (r_state == ST_CALC) && (r_cnt == CW'(1));
    assign stall    = w_accept || (r_state == ST_CALC);

    // Magnitudes in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
    assign w_dvd_neg = is_signed && dividend[WIDTH-1];
    assign w_dsr_neg = is_signed && divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dsr_mag = w_dsr_neg ? (~divisor + WIDTH'(1)) : divisor;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .i_p (r_p),
        .i_q (r_q),
        .i_d (r_d),
        .o_p (w_p_nxt),
        .o_q (w_q_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start)  w_state_nxt = ST_CALC;
                ST_CALC: if (w_last) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Iteration datapath: operands latched on accept, one step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p       <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_dvd_raw <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dz      <= 1'b0;
        end else if (clear) begin
            r_p       <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_dvd_raw <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            r_p       <= '0;
            r_q       <= w_dvd_mag;
            r_d       <= w_dsr_mag;
            r_dvd_raw <= dividend;
            r_cnt     <= CW'(WIDTH);
            r_sign_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_sign_r  <= w_dvd_neg;
            r_dz      <= (divisor == '0);
        end else if (r_state == ST_CALC) begin
            r_p   <= w_p_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Results are written on the final step and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            busy <= (w_state_nxt == ST_CALC);
            done <= (w_state_nxt == ST_DONE);
            if (clear || w_accept) begin
                quotient  <= '0;
                remainder <= '0;
                div_zero  <= 1'b0;
            end else if (w_last) begin
                div_zero <= r_dz;
                if (r_dz) begin
                    quotient  <= '1;
                    remainder <= r_dvd_raw;
                end else begin
                    quotient  <= r_sign_q ? -w_q_nxt : w_q_nxt;
                    remainder <= r_sign_r ? -w_p_nxt[WIDTH-1:0] : w_p_nxt[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, randomized operands
// against an arithmetic reference model, and flush/reset/ignored-start sequences.
module tb_div_unit;

    localparam int unsigned W   = 32;
    localparam int          LAT = 32;
    localparam int          MAXWAIT = 60;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dsr;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl [10];

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation, remainder follows dividend.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        dz = (b == '0);
        if (dz) begin
            q = '1;
            r = a;
            return;
        end
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'b0, a});
            lb = longint'({32'b0, b});
        end
        lq = la / lb;
        lr = la % lb;
        q  = lq[W-1:0];
        r  = lr[W-1:0];
    endfunction

    // Issue one op right after a negedge; check latency, results and hold.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int tag);
        int e;
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        #1;
        chk($sformatf("stall_accept[%0d]", tag), 64'(stall), 64'(1));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk($sformatf("busy[%0d]", tag), 64'(busy), 64'(1));
        e = 0;
        while (done !== 1'b1 && e < MAXWAIT) begin
            @(negedge clk);
            e++;
        end
        chk($sformatf("latency[%0d]", tag), 64'(e), 64'(LAT));
        chk($sformatf("quotient[%0d]", tag), 64'(quotient), 64'(eq));
        chk($sformatf("remainder[%0d]", tag), 64'(remainder), 64'(er));
        chk($sformatf("div_zero[%0d]", tag), 64'(div_zero), 64'(edz));
        chk($sformatf("stall_done[%0d]", tag), 64'(stall), 64'(0));
        @(negedge clk);
        chk($sformatf("done_pulse[%0d]", tag), 64'({done, busy}), 64'(0));
        chk($sformatf("hold[%0d]", tag), 64'({quotient, remainder}), {eq, er});
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rq;
        logic [W-1:0] rr;
        logic         rs;
        logic         rdz;
        int           e;
        int           pulses;
        int           stall_bad;

        tbl[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
        tbl[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tbl[2] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0};
        tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0};
        tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0};
        tbl[5] = '{32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1};
        tbl[6] = '{32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
        tbl[7] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0};
        tbl[8] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2,         32'hFFFF_FFFE, 1'b0};
        tbl[9] = '{32'd3,         32'd10,        1'b0, 32'd0,         32'd3,         1'b0};

        rst = 1'b1; clear = 1'b0; start = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_flags", 64'({stall, busy, done, div_zero}), 64'(0));
        chk("reset_results", 64'({quotient, remainder}), 64'(0));

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].dvd, tbl[i].dsr, tbl[i].sgn, tbl[i].q, tbl[i].r, tbl[i].dz, i);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = W'(0) - W'($urandom_range(1, 15));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, rq, rr, rdz);
            run_op(ra, rb, rs, rq, rr, rdz, 100 + i);
        end

        // New start mid-iteration must be ignored; stall covers every CALC cycle.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        #1;
        stall_bad = (stall === 1'b1) ? 0 : 1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (done !== 1'b1 && e < MAXWAIT) begin
            if (stall !== 1'b1) stall_bad++;
            if (e == 10) begin
                start = 1'b1; is_signed = 1'b1; dividend = 32'd999; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        chk("ign_latency", 64'(e), 64'(LAT));
        chk("ign_stall_cycles_bad", 64'(stall_bad), 64'(0));
        chk("ign_result", 64'({quotient, remainder}), {32'd14, 32'd2});
        chk("ign_stall_done", 64'(stall), 64'(0));
        @(negedge clk);

        // Flush during CALC.
        start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF_F000; divisor = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_flags", 64'({stall, busy, done, div_zero}), 64'(0));
        chk("clr_results", 64'({quotient, remainder}), 64'(0));
        count_done(LAT + 8, pulses);
        chk("clr_no_done", 64'(pulses), 64'(0));

        // Leave results nonzero, then async reset in the middle of a second op.
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 200);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_flags", 64'({stall, busy, done, div_zero}), 64'(0));
        chk("rst_results", 64'({quotient, remainder}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        count_done(LAT + 8, pulses);
        chk("rst_no_done", 64'(pulses), 64'(0));
        run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 201);

        // start together with clear is not accepted.
        start = 1'b1; clear = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        #1;
        chk("sc_stall", 64'(stall), 64'(0));
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("sc_busy", 64'(busy), 64'(0));
        chk("sc_results", 64'({quotient, remainder}), 64'(0));
        count_done(LAT + 8, pulses);
        chk("sc_no_done", 64'(pulses), 64'(0));
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 202);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
